// File: rtl/roce_rnr_timer_bank_pkg.sv
// Shared RoCE RNR timer constants: IB RNR timer code table, retry encoding and
// the helper that turns a clock period into a 10 us prescaler count.
package roce_rnr_timer_bank_pkg;

    localparam int unsigned RNR_TICK_US = 10;

    // rnr_retry value that IB defines as "retry forever"
    localparam logic [2:0] RNR_RETRY_INFINITE = 3'd7;

    typedef logic [16:0] rnr_ticks_t;

    // IB RNR NAK timer field decoded to 10 us units; code 0 is the longest delay.
    localparam logic [0:31][16:0] RNR_TIMER_TICKS = {
        17'd65536, 17'd1,     17'd2,     17'd3,     17'd4,     17'd6,     17'd8,     17'd12,
        17'd16,    17'd24,    17'd32,    17'd48,    17'd64,    17'd96,    17'd128,   17'd192,
        17'd256,   17'd384,   17'd512,   17'd768,   17'd1024,  17'd1536,  17'd2048,  17'd3072,
        17'd4096,  17'd6144,  17'd8192,  17'd12288, 17'd16384, 17'd24576, 17'd32768, 17'd49152
    };

    localparam logic [1:0] QP_IDLE    = 2'd0;
    localparam logic [1:0] QP_RUNNING = 2'd1;
    localparam logic [1:0] QP_PENDING = 2'd2;

    function automatic int unsigned tick_cycles(input int unsigned clock_period_ns);
        if (clock_period_ns == 0) begin
            return 1;
        end
        return (RNR_TICK_US * 1000 + clock_period_ns / 2) / clock_period_ns;
    endfunction

endpackage

// File: rtl/roce_rnr_timer_bank_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module roce_rnr_timer_bank_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] slot;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        slot        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // ptr and i are both below NUM_REQ, so one subtraction wraps
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            slot = sum[IDX_W-1:0];
            if (!grant_valid && req[slot]) begin
                grant_valid = 1'b1;
                grant[slot] = 1'b1;
                grant_idx   = slot;
            end
        end
    end

endmodule

// File: rtl/roce_rnr_timer_bank.sv
// Per-QP RNR back-off timer bank: arm with an IB RNR code, count in 10 us ticks,
// report expiries (or retry exhaustion) one at a time through a stream register.
module roce_rnr_timer_bank
    import roce_rnr_timer_bank_pkg::*;
#(
    parameter int unsigned NUM_QP           = 4,
    parameter int unsigned NET_CLOCK_PERIOD = 4,
    parameter int unsigned QP_W             = (NUM_QP > 1) ? $clog2(NUM_QP) : 1,
    parameter int unsigned TICK_CYCLES      = tick_cycles(NET_CLOCK_PERIOD),
    parameter int unsigned RNR_RETRY_LIMIT  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_arm_valid,
    input  logic [QP_W-1:0]   s_arm_qp,
    input  logic [4:0]        s_arm_rnr_code,
    input  logic              s_cancel_valid,
    input  logic [QP_W-1:0]   s_cancel_qp,
    output logic              m_expire_valid,
    input  logic              m_expire_ready,
    output logic [QP_W-1:0]   m_expire_qp,
    output logic              m_expire_exhausted,
    output logic [NUM_QP-1:0] busy
);

    localparam int unsigned PRE_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [2:0]  LIMIT   = 3'(RNR_RETRY_LIMIT);
    localparam bit          LIMITED = (LIMIT != RNR_RETRY_INFINITE);

    logic [PRE_W-1:0]  pre_q;
    logic              tick;
    logic              load;
    logic [NUM_QP-1:0] pend_req;
    logic [NUM_QP-1:0] arb_req;
    logic [NUM_QP-1:0] grant;
    logic [QP_W-1:0]   grant_idx;
    logic              grant_valid;
    logic [NUM_QP-1:0] exh_vec;
    logic [QP_W-1:0]   rr_ptr_q;

    assign tick = (pre_q == PRE_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    for (genvar q = 0; q < NUM_QP; q++) begin : g_qp
        logic [1:0]  state_q;
        rnr_ticks_t  cnt_q;
        logic [2:0]  retry_q;
        logic        exh_q;
        logic        arm_hit;
        logic        cancel_hit;

        assign arm_hit    = s_arm_valid && (s_arm_qp == QP_W'(q));
        assign cancel_hit = s_cancel_valid && (s_cancel_qp == QP_W'(q));
        // An arm or cancel this cycle supersedes a pending event, so it is not offered
        assign pend_req[q] = (state_q == QP_PENDING) && !arm_hit && !cancel_hit;
        assign busy[q]     = (state_q == QP_RUNNING);
        assign exh_vec[q]  = exh_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= QP_IDLE;
                cnt_q   <= '0;
                retry_q <= '0;
                exh_q   <= 1'b0;
            end else if (cancel_hit) begin
                state_q <= QP_IDLE;
                retry_q <= '0;
                exh_q   <= 1'b0;
            end else if (arm_hit) begin
                if (LIMITED && (retry_q == LIMIT)) begin
                    state_q <= QP_PENDING;
                    exh_q   <= 1'b1;
                end else begin
                    state_q <= QP_RUNNING;
                    cnt_q   <= RNR_TIMER_TICKS[s_arm_rnr_code];
                    exh_q   <= 1'b0;
                end
                if (LIMITED && (retry_q != 3'd7)) begin
                    retry_q <= retry_q + 3'd1;
                end
            end else if (grant[q]) begin
                state_q <= QP_IDLE;
            end else if ((state_q == QP_RUNNING) && tick) begin
                cnt_q <= cnt_q - 17'd1;
                if (cnt_q == 17'd1) begin
                    state_q <= QP_PENDING;
                    exh_q   <= 1'b0;
                end
            end
        end
    end

    // The output slot may take a new event when empty or when it drains this cycle
    assign load    = !m_expire_valid || m_expire_ready;
    assign arb_req = load ? pend_req : '0;

    roce_rnr_timer_bank_rr_arbiter #(
        .NUM_REQ (NUM_QP),
        .IDX_W   (QP_W)
    ) u_rr_arbiter (
        .req         (arb_req),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_expire_valid     <= 1'b0;
            m_expire_qp        <= '0;
            m_expire_exhausted <= 1'b0;
            rr_ptr_q           <= '0;
        end else if (load) begin
            m_expire_valid <= grant_valid;
            if (grant_valid) begin
                m_expire_qp        <= grant_idx;
                m_expire_exhausted <= exh_vec[grant_idx];
                if (grant_idx == QP_W'(NUM_QP - 1)) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= grant_idx + QP_W'(1);
                end
            end
        end
    end

endmodule
